// File: rtl/tinyqv_debug_pkg.sv
// Shared definitions for the debug UART transmit path.
// Contents: store-size encodings (write_n), drain FSM state type, and
// size_to_bytes(), which maps a store size to the number of bytes it carries.
package tinyqv_debug_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } drain_state_e;

  // Bytes carried by a store of the given size; 0 for "no write".
  function automatic logic [2:0] size_to_bytes(input logic [1:0] wr_size);
    logic [2:0] n;
    case (wr_size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/debug_fifo_mem.sv
// DEPTH x 8 storage for the debug UART transmit FIFO.
// Ports:
//   clk        - system clock
//   wr_mask    - per-lane write enable; lane i lands at wr_base + i
//   wr_base    - slot for lane 0 of the store
//   wr_data    - store data, lane i = wr_data[8*i +: 8]
//   rd_ptr     - read slot
//   rd_data_c  - combinational read of slot rd_ptr
// Storage has no reset: validity is tracked by the pointers and level
// counter in the parent.
module debug_fifo_mem
  import tinyqv_debug_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic [3:0]                 wr_mask,
  input  logic [$clog2(DEPTH)-1:0]   wr_base,
  input  logic [31:0]                wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [7:0]                 rd_data_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0] mem_q [DEPTH];

  // Lanes map to consecutive slots; the slot index wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_mask[i]) begin
        mem_q[wr_base + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data_c = mem_q[rd_ptr];

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Byte FIFO between CPU stores to the debug UART data register and the
// uart_tx serializer. Byte/half/word stores are split little-endian into
// bytes; a drain FSM hands bytes to the serializer one at a time.
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   wr_valid      - store to the debug UART data address this cycle
//   wr_size       - 00 byte, 01 half, 10 word, 11 no write
//   wr_data       - store data, byte 0 = wr_data[7:0]
//   clr_overflow  - clears sticky overflow (and disarms low-water irq)
//   tx_busy       - serializer busy
//   tx_start      - one-cycle start pulse to the serializer
//   tx_data       - byte for the serializer, held until the next start
//   level         - bytes queued
//   empty, full   - level == 0 / level == DEPTH
//   overflow      - sticky: a store was dropped for lack of space
//   irq_low       - low-water interrupt
// Build option: define DEBUG_UART_FIFO_IRQ_EN to include the low-water
// interrupt; otherwise irq_low is constant 0.
module debug_uart_tx_fifo
  import tinyqv_debug_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LOW_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [1:0]               wr_size,
  input  logic [31:0]              wr_data,
  input  logic                     clr_overflow,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     irq_low
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // Reject configurations the pointer/level arithmetic does not support.
  if ((DEPTH < 4) || ((1 << AW) != DEPTH) || (LOW_THRESH >= DEPTH)) begin : g_bad_cfg
    $error("debug_uart_tx_fifo: DEPTH must be a power of 2 >= 4 and LOW_THRESH < DEPTH");
  end

  drain_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;

  logic [2:0]    n_bytes;
  logic          push_req;
  logic          accept;
  logic          pop;
  logic [3:0]    wr_mask;
  logic [7:0]    rd_data_c;

  debug_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_mask   (wr_mask),
    .wr_base   (wr_ptr_q),
    .wr_data   (wr_data),
    .rd_ptr    (rd_ptr_q),
    .rd_data_c (rd_data_c)
  );

  // Store acceptance: all-or-nothing against the level before any pop.
  always_comb begin
    n_bytes  = size_to_bytes(wr_size);
    push_req = wr_valid && (wr_size != SIZE_NONE);
    accept   = push_req && ((LW'(DEPTH) - level_q) >= LW'(n_bytes));
    wr_mask  = 4'b0000;
    if (accept) begin
      case (n_bytes)
        3'd1:    wr_mask = 4'b0001;
        3'd2:    wr_mask = 4'b0011;
        3'd4:    wr_mask = 4'b1111;
        default: wr_mask = 4'b0000;
      endcase
    end
  end

  // Next-state: pointers, level, overflow and the drain FSM.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((level_q != '0) && !tx_busy) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = rd_data_c;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          state_d    = ST_GUARD;
        end
      end
      // Serializer raises busy one cycle after the start pulse; skip that cycle.
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    wr_ptr_d = accept ? (wr_ptr_q + AW'(n_bytes)) : wr_ptr_q;
    level_d  = level_q + (accept ? LW'(n_bytes) : LW'(0)) - (pop ? LW'(1) : LW'(0));

    // Set wins over clear.
    if (push_req && !accept) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    empty_d = (level_d == LW'(0));
    full_d  = (level_d == LW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

`ifdef DEBUG_UART_FIFO_IRQ_EN
  logic armed_q, armed_d;
  logic irq_low_q, irq_low_d;

  // Arms once the FIFO rises above the threshold; clr_overflow acknowledges.
  always_comb begin
    armed_d = armed_q;
    if (clr_overflow) begin
      armed_d = 1'b0;
    end else if (level_d > LW'(LOW_THRESH)) begin
      armed_d = 1'b1;
    end
    irq_low_d = armed_d && (level_d <= LW'(LOW_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      irq_low_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      irq_low_q <= irq_low_d;
    end
  end

  assign irq_low = irq_low_q;
`else
  assign irq_low = 1'b0;
`endif

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign level    = level_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Bench for debug_uart_tx_fifo: queue-based reference model, a per-cycle
// compare process, a simple serializer model, directed scenarios and a
// randomized phase.
module tb_debug_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int LOW   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        clr_overflow;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        irq_low;

  debug_uart_tx_fifo #(.DEPTH(DEPTH), .LOW_THRESH(LOW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_size      (wr_size),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .irq_low      (irq_low)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serializer model: busy for 1..6 cycles starting the cycle after it sees tx_start.
  int ser_cnt = 0;
  bit hold_busy = 1'b0;
  assign tx_busy = hold_busy || (ser_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) ser_cnt <= int'($urandom_range(6, 1));
    else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
  end

  // Reference model: byte queue, sticky overflow, one-cycle guard after each start.
  byte unsigned mq[$];
  bit           m_ovf, m_guard, m_start, m_armed, m_irq;
  logic [7:0]   m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_guard = 0; m_start = 0; m_data = 8'h00; m_armed = 0; m_irq = 0;
    end else begin : step
      int n;
      bit push, acc, pop;
      n    = (wr_size == 2'd0) ? 1 : (wr_size == 2'd1) ? 2 : (wr_size == 2'd2) ? 4 : 0;
      push = wr_valid && (wr_size != 2'd3);
      acc  = push && ((DEPTH - mq.size()) >= n);
      pop  = !m_guard && (mq.size() > 0) && !tx_busy;
      m_start = pop;
      if (pop) m_data = mq.pop_front();
      if (acc) for (int i = 0; i < n; i++) mq.push_back(wr_data[8*i +: 8]);
      if (push && !acc) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      m_guard = pop;
`ifdef DEBUG_UART_FIFO_IRQ_EN
      if (clr_overflow) m_armed = 0;
      else if (mq.size() > LOW) m_armed = 1;
      m_irq = m_armed && (mq.size() <= LOW);
`else
      m_irq = 0;
`endif
    end
  end

  // Per-cycle compare plus capture of bytes actually sent.
  byte unsigned obs[$];
  int cyc = 0;
  int last_start = -100;

  always @(negedge clk) begin
    cyc++;
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("level",    32'(level),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("irq_low",  32'(irq_low),  32'(m_irq));
    if (rst) begin
      last_start = -100;
    end else if (tx_start) begin
      obs.push_back(tx_data);
      chk("start_gap", 32'((cyc - last_start) >= 2), 32'd1);
      last_start = cyc;
    end
  end

  task automatic drive(input logic [1:0] size, input logic [31:0] data);
    wr_valid = 1'b1; wr_size = size; wr_data = data;
    @(negedge clk);
    wr_valid = 1'b0; wr_size = 2'b11;
  endtask

  task automatic clr_ovf();
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
  endtask

  task automatic drain();
    int k;
    hold_busy = 1'b0; wr_valid = 1'b0; clr_overflow = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (mq.size() == 0 && ser_cnt == 0 && !m_guard) break;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(k < 400), 32'd1);
    chk("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    byte unsigned exp_b[$];
    int k;
    rst = 1'b1; wr_valid = 1'b0; wr_size = 2'b11; wr_data = '0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: start pulse one edge after the push edge.
    drive(2'b00, 32'h41);
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    drain();

    // Word held behind busy, then released: little-endian order.
    hold_busy = 1'b1; obs.delete();
    drive(2'b10, 32'h44332211);
    chk("t2_level", 32'(level), 32'd4);
    repeat (3) @(negedge clk);
    chk("t2_no_start", 32'(obs.size()), 32'd0);
    drain();
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("t2_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("t2_byte", 32'(obs[i]), 32'(exp_b[i]));

    // Fill to full, overflow on extra byte, clear.
    hold_busy = 1'b1; obs.delete();
    drive(2'b10, 32'h03020100);
    drive(2'b10, 32'h07060504);
    chk("t3_level", 32'(level), 32'd8);
    chk("t3_full", 32'(full), 32'd1);
    drive(2'b00, 32'hAA);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_level_kept", 32'(level), 32'd8);
    clr_ovf();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    drain();
    chk("t3_count", 32'(obs.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) chk("t3_byte", 32'(obs[i]), 32'(i));

    // Half store at level 7 rejected whole.
    hold_busy = 1'b1; obs.delete();
    drive(2'b10, 32'h13121110);
    drive(2'b01, 32'h00001514);
    drive(2'b00, 32'h16);
    chk("t4_level", 32'(level), 32'd7);
    drive(2'b01, 32'h0000BBAA);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_level_kept", 32'(level), 32'd7);
    clr_ovf();
    drain();
    chk("t4_count", 32'(obs.size()), 32'd7);
    for (int i = 0; i < 7 && i < obs.size(); i++) chk("t4_byte", 32'(obs[i]), 32'h10 + 32'(i));

    // Push and pop in the same cycle at full: push rejected on pre-pop level.
    hold_busy = 1'b1;
    drive(2'b10, 32'h23222120);
    drive(2'b10, 32'h27262524);
    hold_busy = 1'b0;
    drive(2'b00, 32'h99);
    chk("t5_level", 32'(level), 32'd7);
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_start", 32'(tx_start), 32'd1);
    chk("t5_data", 32'(tx_data), 32'h20);
    clr_ovf();
    drain();

    // 20 bytes through the FIFO: pointers wrap several times.
    obs.delete();
    for (int i = 0; i < 20; i++) begin
      for (k = 0; k < 200 && level >= 4'(DEPTH); k++) @(negedge clk);
      if (k >= 200) chk("t5_space_timeout", 32'(k), 32'd0);
      drive(2'b00, 32'h30 + 32'(i));
    end
    drain();
    chk("t5_wrap_count", 32'(obs.size()), 32'd20);
    for (int i = 0; i < 20 && i < obs.size(); i++) chk("t5_wrap_byte", 32'(obs[i]), 32'h30 + 32'(i));

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      wr_valid     = $urandom_range(1, 0) == 1;
      wr_size      = 2'($urandom_range(3, 0));
      wr_data      = $urandom;
      clr_overflow = $urandom_range(7, 0) == 0;
      hold_busy    = $urandom_range(5, 0) == 0;
      @(negedge clk);
    end
    wr_valid = 1'b0; clr_overflow = 1'b0;
    drain();
    clr_ovf();

    // Asynchronous reset mid-drain.
    hold_busy = 1'b1;
    drive(2'b10, 32'h53525150);
    drive(2'b00, 32'h54);
    chk("t6_level", 32'(level), 32'd5);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_start", 32'(tx_start), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'd0);
    chk("t6_rst_irq", 32'(irq_low), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    repeat (12) @(negedge clk);
    chk("t6_no_residual", 32'(obs.size()), 32'd0);
    chk("t6_level_after", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/debug_uart_tx_fifo.md
Name: debug_uart_tx_fifo

Overview:
- Byte FIFO that buffers CPU writes to the debug UART data register and feeds the uart_tx serializer.
- Sits between the top-level peripheral decode (PERI_DEBUG_UART) and uart_tx.
- Accepts byte, half-word and word stores: 1, 2 or 4 bytes, little-endian.
- Exposes level and full/overflow status so firmware can poll instead of spinning on tx busy.

Parameters:
- DEPTH, 8: FIFO depth in bytes. Power of 2, minimum 4.
- LOW_THRESH, 2: level at or below which the optional low-water IRQ asserts.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  store targets the debug UART data address this cycle.
- wr_size  in  2  write_n encoding: 00 byte, 01 half, 10 word, 11 no write.
- wr_data  in  32  store data; byte 0 = wr_data[7:0].
- clr_overflow  in  1  clears the sticky overflow flag.
- tx_busy  in  1  uart_tx_busy from the serializer.
- tx_start  out  1  registered one-cycle start pulse to uart_tx_en.
- tx_data  out  8  registered byte to uart_tx_data; stable while the serializer is busy.
- level  out  $clog2(DEPTH)+1  bytes currently queued.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; a store was dropped.
- irq_low  out  1  low-water interrupt; 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst=1): pointers 0, level 0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, irq_low=0, FSM in IDLE.
- Reset mid-transmission discards all queued bytes. uart_tx has its own reset.
- Store handling:
  - N = 1, 2 or 4 from wr_size. A push occurs when wr_valid && wr_size != 11.
  - Space check uses the level before any same-cycle pop: accept iff DEPTH - level >= N.
  - On accept, bytes are written in order byte0..byte(N-1) at consecutive wr_ptr slots, and wr_ptr += N mod DEPTH.
  - On reject, nothing is written (no partial store) and overflow is set.
- level update: level_next = level + pushed - popped. A simultaneous push and pop is legal.
- Pointers: $clog2(DEPTH) bits each and wrap naturally. level is a separate counter; full/empty are derived from level.
- overflow: set on reject; cleared by clr_overflow. If both happen in the same cycle, set wins.
- Drain FSM:
  - IDLE: if !empty && !tx_busy, then on the next edge tx_start=1, tx_data=mem[rd_ptr], rd_ptr++, level-- (pop). Go to GUARD.
  - GUARD: tx_start=0. tx_busy is ignored for exactly one cycle to cover the serializer's busy-assert latency. Go to IDLE.
  - IDLE re-checks tx_busy, so the next byte issues only after the serializer deasserts busy.
- Latency: a byte pushed at edge E into an empty FIFO, with tx_busy=0, produces tx_start=1 after edge E+1.
- Back-to-back tx_start pulses are at least 2 cycles apart.
- Byte order on the wire equals push order. A word 0x44332211 transmits 11, 22, 33, 44.

Optional Feature:
- Macro: DEBUG_UART_FIFO_IRQ_EN.
- Defined: irq_low is registered, = (level_next <= LOW_THRESH) && armed.
  - armed sets once level exceeds LOW_THRESH.
  - armed clears when irq_low is taken, i.e. on clr_overflow; the same strobe reuses the clear path.
  - Reset value 0.
- Undefined: irq_low is tied to 0, and no armed flop or comparator is synthesized.

Decomposition:
- Shared package tinyqv_debug_pkg holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_NONE=2'b11;
  - FSM state enum {ST_IDLE, ST_GUARD};
  - function size_to_bytes(wr_size) returning 0/1/2/4.
- One sub-module, debug_fifo_mem: a DEPTH x 8 register array with a 4-byte-wide write port (write mask, base pointer) and a 1-byte read port.
- Control, level and FSM stay in debug_uart_tx_fifo.

Test Plan:
- Reset, then a byte write 0x41 with tx_busy=0 -> tx_start pulses 1 cycle at E+1 with tx_data=0x41; level returns to 0; empty=1.
- Word write 0x44332211 while tx_busy held 1 -> level=4 and no tx_start. Release busy with a model uart_tx -> bytes 11, 22, 33, 44 in order, each pulse ≥2 cycles apart.
- DEPTH=8: two word writes -> level=8, full=1. Then a byte write -> dropped, overflow=1, level stays 8. clr_overflow -> overflow=0.
- level=7 (busy held), then a half write -> rejected whole, overflow=1, and the FIFO contents are unchanged when drained.
- Simultaneous push of a byte and pop at level=8 -> push rejected (pre-pop check), level=7. Then pointer wrap after 20 bytes drained -> all data correct.
- Assert rst mid-drain with level=5 -> outputs return to reset values immediately (async). After release, no residual tx_start occurs.
